// File: rtl/hs_mem_responder.sv
// Word-organised RAM responder for the req/ack/err handshake bus with configurable wait states.
// Optional macro HS_MEM_MISALIGN_ERR_EN: reject in-range accesses whose byte address is not word aligned.
module hs_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_req,
  input  logic        s_wr,
  input  logic [3:0]  s_be,
  input  logic [31:0] s_addr,
  input  logic [31:0] s_data_i,
  output logic        s_ack,
  output logic        s_err,
  output logic [31:0] s_data_o
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        wr_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        cur_wr;
  logic [3:0]  cur_be;
  logic [31:0] cur_addr;
  logic [31:0] cur_data;
  logic        fire;
  logic [32:0] addr_ext;
  logic [32:0] lo_bound;
  logic [32:0] hi_bound;
  logic        in_range;
  logic        misalign;
  logic        access_ok;
  logic [31:0] offset;
  logic [AW-1:0] idx;
  logic        do_write;

  // With zero wait states the response is registered on the acceptance edge,
  // so the transaction being completed comes straight from the bus in IDLE.
  always_comb begin
    cur_wr   = wr_q;
    cur_be   = be_q;
    cur_addr = addr_q;
    cur_data = data_q;
    if (state == IDLE) begin
      cur_wr   = s_wr;
      cur_be   = s_be;
      cur_addr = s_addr;
      cur_data = s_data_i;
    end else begin
      cur_wr   = wr_q;
      cur_be   = be_q;
      cur_addr = addr_q;
      cur_data = data_q;
    end
    case (state)
      IDLE:    fire = s_req && (WAIT_STATES == 0);
      WAIT:    fire = (cnt == 4'd1);
      default: fire = 1'b0;
    endcase
  end

  // Address decode in 33 bits so the top of the window cannot wrap past 2^32.
  always_comb begin
    addr_ext = {1'b0, cur_addr};
    lo_bound = {1'b0, BASE_ADDR};
    hi_bound = lo_bound + (33'(DEPTH_WORDS) << 2);
    in_range = (addr_ext >= lo_bound) && (addr_ext < hi_bound);
    offset   = cur_addr - BASE_ADDR;
    idx      = AW'(offset >> 2);
`ifdef HS_MEM_MISALIGN_ERR_EN
    misalign = (cur_addr[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif
    access_ok = in_range && !misalign;
    do_write  = fire && access_ok && cur_wr && !reset;
  end

  // Byte-lane writes into the storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int n = 0; n < 4; n++) begin
        if (cur_be[n]) begin
          mem[idx][8*n +: 8] <= cur_data[8*n +: 8];
        end
      end
    end
  end

  // Handshake FSM with registered ack/err/read-data outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      wr_q     <= 1'b0;
      be_q     <= 4'd0;
      addr_q   <= 32'd0;
      data_q   <= 32'd0;
      s_ack    <= 1'b0;
      s_err    <= 1'b0;
      s_data_o <= 32'd0;
    end else begin
      s_ack <= 1'b0;
      s_err <= 1'b0;
      case (state)
        IDLE: begin
          if (s_req) begin
            wr_q   <= s_wr;
            be_q   <= s_be;
            addr_q <= s_addr;
            data_q <= s_data_i;
            cnt    <= 4'(WAIT_STATES);
            state  <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (fire) begin
        s_ack    <= access_ok;
        s_err    <= !access_ok;
        s_data_o <= (access_ok && !cur_wr) ? mem[idx] : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_hs_mem_responder.sv
// Table-driven bench for hs_mem_responder: three instances with 0, 3 and 5 wait states.
module tb_hs_mem_responder;

  localparam logic [31:0] B = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req  [3];
  logic        wr   [3];
  logic [3:0]  be   [3];
  logic [31:0] addr [3];
  logic [31:0] wdat [3];
  logic        ack  [3];
  logic        err  [3];
  logic [31:0] rdo  [3];

  int checks = 0;
  int errors = 0;
  int ws [3] = '{0, 3, 5};

  always #5 clk = ~clk;

  hs_mem_responder #(.BASE_ADDR(B), .DEPTH_WORDS(16), .WAIT_STATES(0)) u0 (
    .clk(clk), .reset(reset), .s_req(req[0]), .s_wr(wr[0]), .s_be(be[0]), .s_addr(addr[0]),
    .s_data_i(wdat[0]), .s_ack(ack[0]), .s_err(err[0]), .s_data_o(rdo[0]));
  hs_mem_responder #(.BASE_ADDR(B), .DEPTH_WORDS(16), .WAIT_STATES(3)) u3 (
    .clk(clk), .reset(reset), .s_req(req[1]), .s_wr(wr[1]), .s_be(be[1]), .s_addr(addr[1]),
    .s_data_i(wdat[1]), .s_ack(ack[1]), .s_err(err[1]), .s_data_o(rdo[1]));
  hs_mem_responder #(.BASE_ADDR(B), .DEPTH_WORDS(16), .WAIT_STATES(5)) u5 (
    .clk(clk), .reset(reset), .s_req(req[2]), .s_wr(wr[2]), .s_be(be[2]), .s_addr(addr[2]),
    .s_data_i(wdat[2]), .s_ack(ack[2]), .s_err(err[2]), .s_data_o(rdo[2]));

  typedef struct {
    int          u;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_txn(input string nm, input vec_t v);
    int n;
    @(negedge clk);
    req[v.u]  = 1'b1;
    wr[v.u]   = v.wr;
    be[v.u]   = v.be;
    addr[v.u] = v.addr;
    wdat[v.u] = v.wdata;
    @(posedge clk);
    #1;
    n = 0;
    while (!(ack[v.u] || err[v.u]) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    req[v.u] = 1'b0;
    chk({nm, " latency"}, 32'(n), 32'(ws[v.u]));
    chk({nm, " ack"}, {31'd0, ack[v.u]}, {31'd0, !v.err});
    chk({nm, " err"}, {31'd0, err[v.u]}, {31'd0, v.err});
    chk({nm, " data"}, rdo[v.u], v.rdata);
    @(posedge clk);
    #1;
    chk({nm, " pulse"}, {30'd0, ack[v.u], err[v.u]}, 32'd0);
  endtask

  initial begin
    vec_t rv;
    logic seen;
    logic [31:0] words [3];

    vecs[0]  = '{0, 1'b1, 4'hF, B,              32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1]  = '{0, 1'b0, 4'hF, B,              32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{0, 1'b0, 4'hF, B + 32'h40,     32'h0,         1'b1, 32'h0};
    vecs[3]  = '{0, 1'b0, 4'hF, B - 32'h4,      32'h0,         1'b1, 32'h0};
    vecs[4]  = '{0, 1'b1, 4'hF, B + 32'h40,     32'h1111_1111, 1'b1, 32'h0};
    vecs[5]  = '{0, 1'b0, 4'hF, B,              32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[6]  = '{0, 1'b1, 4'hF, B + 32'h4,      32'h1234_5678, 1'b0, 32'h0};
    vecs[7]  = '{0, 1'b1, 4'hF, B + 32'h8,      32'hCAFE_F00D, 1'b0, 32'h0};
    vecs[8]  = '{0, 1'b1, 4'h0, B + 32'h4,      32'hAAAA_AAAA, 1'b0, 32'h0};
    vecs[9]  = '{0, 1'b0, 4'hF, B + 32'h4,      32'h0,         1'b0, 32'h1234_5678};
    vecs[10] = '{0, 1'b1, 4'hF, B + 32'h3C,     32'h0BAD_F00D, 1'b0, 32'h0};
    vecs[11] = '{0, 1'b0, 4'hF, B + 32'h3C,     32'h0,         1'b0, 32'h0BAD_F00D};
`ifdef HS_MEM_MISALIGN_ERR_EN
    vecs[12] = '{0, 1'b0, 4'hF, B + 32'h2,      32'h0,         1'b1, 32'h0};
`else
    vecs[12] = '{0, 1'b0, 4'hF, B + 32'h2,      32'h0,         1'b0, 32'hDEAD_BEEF};
`endif
    vecs[13] = '{0, 1'b0, 4'hF, 32'hFFFF_FFFC,  32'h0,         1'b1, 32'h0};
    vecs[14] = '{1, 1'b1, 4'hF, B,              32'hFFFF_FFFF, 1'b0, 32'h0};
    vecs[15] = '{1, 1'b1, 4'h5, B,              32'h1122_3344, 1'b0, 32'h0};
    vecs[16] = '{1, 1'b0, 4'hF, B,              32'h0,         1'b0, 32'hFF22_FF44};
    vecs[17] = '{2, 1'b1, 4'hF, B + 32'h8,      32'h5566_7788, 1'b0, 32'h0};
    vecs[18] = '{2, 1'b0, 4'hF, B + 32'h8,      32'h0,         1'b0, 32'h5566_7788};

    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; wr[i] = 1'b0; be[i] = 4'h0; addr[i] = 32'h0; wdat[i] = 32'h0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset u%0d outs", i), {ack[i] | err[i], rdo[i][30:0]}, 32'd0);
    end

    for (int i = 0; i < 19; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i]);
    end

    // s_req held high across three reads on the zero-wait instance.
    words[0] = 32'hDEAD_BEEF; words[1] = 32'h1234_5678; words[2] = 32'hCAFE_F00D;
    @(negedge clk);
    req[0] = 1'b1; wr[0] = 1'b0; be[0] = 4'hF; addr[0] = B;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("b2b ack k%0d", k), {31'd0, ack[0]}, {31'd0, (k % 2 == 0) && (k < 6)});
      if (k % 2 == 0) begin
        chk($sformatf("b2b data k%0d", k), rdo[0], words[k / 2]);
        addr[0] = B + 32'(4 * (k / 2 + 1));
      end
      if (k == 4) req[0] = 1'b0;
    end
    chk("b2b hold data", rdo[0], 32'hCAFE_F00D);

    // Reset during WAIT of a write on the five-wait instance drops the write.
    @(negedge clk);
    req[2] = 1'b1; wr[2] = 1'b1; be[2] = 4'hF; addr[2] = B + 32'h8; wdat[2] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rst mid outs", {ack[2] | err[2], rdo[2][30:0]}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    req[2] = 1'b0;
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (ack[2] || err[2]) seen = 1'b1;
    end
    chk("rst no pulse", {31'd0, seen}, 32'd0);
    rv = '{2, 1'b0, 4'hF, B + 32'h8, 32'h0, 1'b0, 32'h5566_7788};
    do_txn("rst readback", rv);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
